// File: rtl/car_motion_if.sv
// Signal bundle between the key/vga front end and the car_motion dynamics engine.
// The master side drives the frame/key inputs; car_motion is the slave that returns race state.
interface car_motion_if;
   logic        vsync_in;
   logic        key_gas;
   logic        key_shift;
   logic        start;
   logic [31:0] position;
   logic [8:0]  speed;
   logic [7:0]  rpm;
   logic [2:0]  gear;
   logic        racing;
   logic        finished;

   modport master (
      output vsync_in, key_gas, key_shift, start,
      input  position, speed, rpm, gear, racing, finished
   );

   modport slave (
      input  vsync_in, key_gas, key_shift, start,
      output position, speed, rpm, gear, racing, finished
   );
endinterface

// File: rtl/car_motion.sv
// Per-player race dynamics: once per video frame (rising vsync) advances rpm, gear,
// speed and track position, sequenced by an IDLE/RACE/FINISH race FSM.
module car_motion #(
   parameter int unsigned RPM_STEP   = 4,
   parameter int unsigned RPM_MAX    = 255,
   parameter int unsigned GEARS      = 5,
   parameter logic [31:0] FINISH_POS = 32'd40000
) (
   input logic         clk,
   input logic         rst,
   car_motion_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RACE,
      FINISH
   } state_t;

   localparam logic [2:0] GEAR_TOP = 3'(GEARS);
   localparam logic [8:0] STEP9    = 9'(RPM_STEP);
   localparam logic [8:0] MAX9     = 9'(RPM_MAX);

   state_t      state, state_nxt;
   logic [31:0] position, position_nxt;
   logic [7:0]  rpm, rpm_nxt;
   logic [2:0]  gear, gear_nxt;
   logic        shift_pend, shift_pend_nxt;
   logic        vs_q;
   logic        shift_q;

   logic        tick;
   logic        shift_edge;
   logic [10:0] product;
   logic [8:0]  speed;
   logic [32:0] pos_sum;
   logic [8:0]  rpm_up;
   logic [8:0]  rpm_dn;
   logic [7:0]  rpm_gas;

   assign tick       = bus.vsync_in & ~vs_q;
   assign shift_edge = bus.key_shift & ~shift_q;

   // 8x3 product never exceeds 255*5, so 11 bits hold it and speed tops out at 318
   assign product = {3'b000, rpm} * {8'h00, gear};
   assign speed   = 9'(product >> 2);
   assign pos_sum = {1'b0, position} + {24'h000000, speed};

   // rpm step with 9-bit headroom, saturating at both ends
   assign rpm_up = {1'b0, rpm} + STEP9;
   assign rpm_dn = {1'b0, rpm} - STEP9;

   always_comb begin
      rpm_gas = rpm;
      if (bus.key_gas) begin
         rpm_gas = (rpm_up > MAX9) ? MAX9[7:0] : rpm_up[7:0];
      end else begin
         rpm_gas = rpm_dn[8] ? 8'h00 : rpm_dn[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_q    <= 1'b0;
         shift_q <= 1'b0;
      end else begin
         vs_q    <= bus.vsync_in;
         shift_q <= bus.key_shift;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         position   <= 32'h0000_0000;
         rpm        <= 8'h00;
         gear       <= 3'd1;
         shift_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         position   <= position_nxt;
         rpm        <= rpm_nxt;
         gear       <= gear_nxt;
         shift_pend <= shift_pend_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      position_nxt   = position;
      rpm_nxt        = rpm;
      gear_nxt       = gear;
      shift_pend_nxt = shift_pend;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RACE;
            end
         end

         RACE: begin
            if (tick) begin
               // A pending shift request is consumed by the tick whether it could be honoured or not
               shift_pend_nxt = 1'b0;
               if (shift_pend && (gear < GEAR_TOP)) begin
                  gear_nxt = gear + 3'd1;
                  rpm_nxt  = rpm >> 1;
               end else begin
                  rpm_nxt = rpm_gas;
               end
               if (pos_sum >= {1'b0, FINISH_POS}) begin
                  position_nxt = FINISH_POS;
                  state_nxt    = FINISH;
               end else begin
                  position_nxt = pos_sum[31:0];
               end
            end else if (shift_edge) begin
               shift_pend_nxt = 1'b1;
            end
         end

         FINISH: begin
            if (bus.start) begin
               state_nxt      = IDLE;
               position_nxt   = 32'h0000_0000;
               rpm_nxt        = 8'h00;
               gear_nxt       = 3'd1;
               shift_pend_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.position = position;
   assign bus.speed    = speed;
   assign bus.rpm      = rpm;
   assign bus.gear     = gear;
   assign bus.racing   = (state == RACE);
   assign bus.finished = (state == FINISH);

   gear_in_range: assert property (@(posedge clk) disable iff (!rst)
      (gear >= 3'd1) && (gear <= GEAR_TOP));

   position_bounded: assert property (@(posedge clk) disable iff (!rst)
      position <= FINISH_POS);

   rpm_bounded: assert property (@(posedge clk) disable iff (!rst)
      {1'b0, rpm} <= MAX9);

endmodule

// File: tb/tb_car_motion.sv
// Directed bench for car_motion: a default-length track instance plus a short-track
// instance (FINISH_POS=100) driven by the same stimulus.
module tb_car_motion;

   logic clk;
   logic rst;
   logic vsync;
   logic gas;
   logic shift;
   logic start;

   int errors = 0;
   int checks = 0;

   car_motion_if bus_main ();
   car_motion_if bus_fin ();

   assign bus_main.vsync_in  = vsync;
   assign bus_main.key_gas   = gas;
   assign bus_main.key_shift = shift;
   assign bus_main.start     = start;
   assign bus_fin.vsync_in   = vsync;
   assign bus_fin.key_gas    = gas;
   assign bus_fin.key_shift  = shift;
   assign bus_fin.start      = start;

   car_motion dut_main (
      .clk (clk),
      .rst (rst),
      .bus (bus_main)
   );

   car_motion #(.FINISH_POS(32'd100)) dut_fin (
      .clk (clk),
      .rst (rst),
      .bus (bus_fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Each frame: vsync high for one cycle, low for two; returns on a negedge
   task automatic applyStimulus(input logic gas_lvl, input int n_ticks);
      gas = gas_lvl;
      repeat (n_ticks) begin
         @(negedge clk) vsync = 1'b1;
         @(negedge clk) vsync = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulseStart();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulseShift();
      @(negedge clk) shift = 1'b1;
      @(negedge clk) shift = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      rst   = 1'b0;
      vsync = 1'b0;
      gas   = 1'b0;
      shift = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);

      // T1: reset values, then ticks in IDLE do nothing
      checkOutput("rst_position", bus_main.position, 32'd0);
      checkOutput("rst_rpm", 32'(bus_main.rpm), 32'd0);
      checkOutput("rst_gear", 32'(bus_main.gear), 32'd1);
      checkOutput("rst_racing", 32'(bus_main.racing), 32'd0);
      checkOutput("rst_finished", 32'(bus_main.finished), 32'd0);
      checkOutput("rst_speed", 32'(bus_main.speed), 32'd0);
      @(negedge clk) rst = 1'b1;
      applyStimulus(1'b1, 10);
      checkOutput("idle_position", bus_main.position, 32'd0);
      checkOutput("idle_rpm", 32'(bus_main.rpm), 32'd0);
      checkOutput("idle_gear", 32'(bus_main.gear), 32'd1);
      checkOutput("idle_racing", 32'(bus_main.racing), 32'd0);

      // T2: start and three gas frames
      pulseStart();
      checkOutput("start_racing", 32'(bus_main.racing), 32'd1);
      applyStimulus(1'b1, 1);
      checkOutput("t2_rpm1", 32'(bus_main.rpm), 32'd4);
      checkOutput("t2_speed1", 32'(bus_main.speed), 32'd1);
      checkOutput("t2_pos1", bus_main.position, 32'd0);
      applyStimulus(1'b1, 1);
      checkOutput("t2_rpm2", 32'(bus_main.rpm), 32'd8);
      checkOutput("t2_speed2", 32'(bus_main.speed), 32'd2);
      checkOutput("t2_pos2", bus_main.position, 32'd1);
      applyStimulus(1'b1, 1);
      checkOutput("t2_rpm3", 32'(bus_main.rpm), 32'd12);
      checkOutput("t2_speed3", 32'(bus_main.speed), 32'd3);
      checkOutput("t2_pos3", bus_main.position, 32'd3);

      // T3: coast back to rpm 0 (pos 9), then saturate and fully release
      applyStimulus(1'b0, 3);
      checkOutput("t3_rpm_zero", 32'(bus_main.rpm), 32'd0);
      checkOutput("t3_pos_start", bus_main.position, 32'd9);
      applyStimulus(1'b1, 63);
      checkOutput("t3_rpm_252", 32'(bus_main.rpm), 32'd252);
      applyStimulus(1'b1, 1);
      checkOutput("t3_rpm_sat", 32'(bus_main.rpm), 32'd255);
      checkOutput("t3_speed_63", 32'(bus_main.speed), 32'd63);
      checkOutput("t3_pos_gas", bus_main.position, 32'd2025);
      applyStimulus(1'b0, 70);
      checkOutput("t3_rpm_floor", 32'(bus_main.rpm), 32'd0);
      checkOutput("t3_speed_floor", 32'(bus_main.speed), 32'd0);
      checkOutput("t3_pos_coast", bus_main.position, 32'd4041);

      // T4: shift at rpm 200, then a double edge inside one frame
      applyStimulus(1'b1, 50);
      checkOutput("t4_rpm_200", 32'(bus_main.rpm), 32'd200);
      pulseShift();
      applyStimulus(1'b1, 1);
      checkOutput("t4_gear2", 32'(bus_main.gear), 32'd2);
      checkOutput("t4_rpm_half", 32'(bus_main.rpm), 32'd100);
      checkOutput("t4_speed50", 32'(bus_main.speed), 32'd50);
      checkOutput("t4_pos", bus_main.position, 32'd5316);
      pulseShift();
      pulseShift();
      applyStimulus(1'b1, 1);
      checkOutput("t4_dbl_gear", 32'(bus_main.gear), 32'd3);
      checkOutput("t4_dbl_rpm", 32'(bus_main.rpm), 32'd50);
      applyStimulus(1'b1, 1);
      checkOutput("t4_dbl_gear_after", 32'(bus_main.gear), 32'd3);
      checkOutput("t4_dbl_rpm_after", 32'(bus_main.rpm), 32'd54);
      checkOutput("t4_dbl_pos", bus_main.position, 32'd5403);

      // T5: climb to top gear, then a shift at the top is dropped
      pulseShift();
      applyStimulus(1'b1, 1);
      pulseShift();
      applyStimulus(1'b1, 1);
      checkOutput("t5_gear5", 32'(bus_main.gear), 32'd5);
      checkOutput("t5_rpm13", 32'(bus_main.rpm), 32'd13);
      checkOutput("t5_pos_g5", bus_main.position, 32'd5470);
      pulseShift();
      applyStimulus(1'b1, 1);
      checkOutput("t5_gear_top", 32'(bus_main.gear), 32'd5);
      checkOutput("t5_rpm_gas", 32'(bus_main.rpm), 32'd17);
      checkOutput("t5_speed", 32'(bus_main.speed), 32'd21);
      checkOutput("t5_pos", bus_main.position, 32'd5486);
      pulseStart();
      checkOutput("race_start_ignored", 32'(bus_main.racing), 32'd1);
      checkOutput("race_start_rpm", 32'(bus_main.rpm), 32'd17);

      // T6: short track run to the finish line
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      checkOutput("t6_rst_pos", bus_fin.position, 32'd0);
      pulseStart();
      applyStimulus(1'b1, 14);
      checkOutput("t6_pos91", bus_fin.position, 32'd91);
      checkOutput("t6_still_racing", 32'(bus_fin.racing), 32'd1);
      applyStimulus(1'b1, 1);
      checkOutput("t6_pos_clamp", bus_fin.position, 32'd100);
      checkOutput("t6_finished", 32'(bus_fin.finished), 32'd1);
      checkOutput("t6_not_racing", 32'(bus_fin.racing), 32'd0);
      checkOutput("t6_rpm_final", 32'(bus_fin.rpm), 32'd60);
      pulseShift();
      applyStimulus(1'b1, 5);
      checkOutput("t6_frozen_pos", bus_fin.position, 32'd100);
      checkOutput("t6_frozen_rpm", 32'(bus_fin.rpm), 32'd60);
      checkOutput("t6_frozen_gear", 32'(bus_fin.gear), 32'd1);
      checkOutput("t6_frozen_fin", 32'(bus_fin.finished), 32'd1);
      pulseStart();
      checkOutput("t6_clr_pos", bus_fin.position, 32'd0);
      checkOutput("t6_clr_rpm", 32'(bus_fin.rpm), 32'd0);
      checkOutput("t6_clr_gear", 32'(bus_fin.gear), 32'd1);
      checkOutput("t6_clr_fin", 32'(bus_fin.finished), 32'd0);
      checkOutput("t6_clr_racing", 32'(bus_fin.racing), 32'd0);

      // Asynchronous reset in the middle of a race, observed before the next clock edge
      pulseStart();
      applyStimulus(1'b1, 5);
      checkOutput("mid_rpm20", 32'(bus_fin.rpm), 32'd20);
      checkOutput("mid_pos10", bus_fin.position, 32'd10);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rpm", 32'(bus_fin.rpm), 32'd0);
      checkOutput("async_pos", bus_fin.position, 32'd0);
      checkOutput("async_gear", 32'(bus_fin.gear), 32'd1);
      checkOutput("async_racing", 32'(bus_fin.racing), 32'd0);
      checkOutput("async_speed", 32'(bus_fin.speed), 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
